// File: rtl/gray_step_arbiter_pkg.sv
// Shared types and helpers for the gray_step_arbiter block: FSM state encoding,
// owner codes, default lockout length and the binary-to-Gray conversion.
package gray_step_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_UP_OWN  = 2'b01,
        ST_DN_OWN  = 2'b10,
        ST_LOCKOUT = 2'b11
    } arb_state_e;

    localparam logic [1:0] OWNER_NONE = 2'b00;
    localparam logic [1:0] OWNER_UP   = 2'b01;
    localparam logic [1:0] OWNER_DN   = 2'b10;

    localparam int LOCKOUT_CYCLES_DEF = 4;
    localparam int GRAY_MAX_W         = 32;

    // Callers zero-extend into and truncate out of the fixed 32-bit carrier.
    function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] bin);
        return bin ^ (bin >> 1);
    endfunction

endpackage

// File: rtl/gray_step_arbiter_pos_tracker.sv
// gray_pos_tracker: holds the counter position in binary and Gray form and emits
// the step strobe. Range clamping with at_limit is enabled by GRAY_STEP_LIMIT_EN.
module gray_pos_tracker
    import gray_step_arbiter_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             step_req,
    input  logic             step_dir,
    output logic             step,
    output logic             step_up,
    output logic [WIDTH-1:0] pos,
    output logic [WIDTH-1:0] pos_gray,
    output logic             at_limit
);

    localparam logic [WIDTH-1:0] POS_ONE = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] POS_MAX = {WIDTH{1'b1}};

    logic [WIDTH-1:0] pos_q, pos_d;
    logic [WIDTH-1:0] pos_gray_q, pos_gray_d;
    logic             step_q, step_d;
    logic             step_up_q, step_up_d;
    logic             at_limit_q, at_limit_d;
    logic             blocked;

    always_comb begin
        blocked    = 1'b0;
`ifdef GRAY_STEP_LIMIT_EN
        blocked    = (step_dir && (pos_q == POS_MAX)) || (!step_dir && (pos_q == '0));
`endif
        pos_d      = pos_q;
        step_d     = 1'b0;
        step_up_d  = 1'b0;
        at_limit_d = 1'b0;
        if (step_req) begin
            if (blocked) begin
                at_limit_d = 1'b1;
            end else begin
                step_d    = 1'b1;
                step_up_d = step_dir;
                pos_d     = step_dir ? (pos_q + POS_ONE) : (pos_q - POS_ONE);
            end
        end
        // Gray code tracks the next position so both outputs update together.
        pos_gray_d = WIDTH'(bin2gray(GRAY_MAX_W'(pos_d)));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pos_q      <= '0;
            pos_gray_q <= '0;
            step_q     <= 1'b0;
            step_up_q  <= 1'b0;
            at_limit_q <= 1'b0;
        end else begin
            pos_q      <= pos_d;
            pos_gray_q <= pos_gray_d;
            step_q     <= step_d;
            step_up_q  <= step_up_d;
            at_limit_q <= at_limit_d;
        end
    end

    assign pos      = pos_q;
    assign pos_gray = pos_gray_q;
    assign step     = step_q;
    assign step_up  = step_up_q;
    assign at_limit = at_limit_q;

endmodule

// File: rtl/gray_step_arbiter.sv
// Grants the shared step-pulse generator to the up or down button, turns returned
// pulses into direction-qualified steps. Optional range clamp: GRAY_STEP_LIMIT_EN.
module gray_step_arbiter
    import gray_step_arbiter_pkg::*;
#(
    parameter int WIDTH          = 4,
    parameter int LOCKOUT_CYCLES = LOCKOUT_CYCLES_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             up_state,
    input  logic             up_posedge,
    input  logic             dn_state,
    input  logic             dn_posedge,
    input  logic             pulse_in,
    output logic             pg_state,
    output logic             pg_posedge,
    output logic             step,
    output logic             step_up,
    output logic [1:0]       owner,
    output logic [WIDTH-1:0] pos,
    output logic [WIDTH-1:0] pos_gray,
    output logic             at_limit
);

    localparam int               CNT_W    = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LOCKOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    arb_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             prio_up_q, prio_up_d;
    logic [1:0]       owner_q, owner_d;
    logic             pg_state_q, pg_state_d;
    logic             pg_posedge_q, pg_posedge_d;
    logic             step_req;
    logic             step_dir;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        prio_up_d    = prio_up_q;
        pg_posedge_d = 1'b0;
        step_req     = 1'b0;
        step_dir     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // On a tie the button that lost the previous grant wins.
                if (up_posedge && (!dn_posedge || prio_up_q)) begin
                    state_d      = ST_UP_OWN;
                    pg_posedge_d = 1'b1;
                    prio_up_d    = 1'b0;
                end else if (dn_posedge) begin
                    state_d      = ST_DN_OWN;
                    pg_posedge_d = 1'b1;
                    prio_up_d    = 1'b1;
                end
            end
            ST_UP_OWN: begin
                step_req = pulse_in;
                step_dir = 1'b1;
                if (!up_state) begin
                    state_d = ST_LOCKOUT;
                    cnt_d   = CNT_LOAD;
                end
            end
            ST_DN_OWN: begin
                step_req = pulse_in;
                step_dir = 1'b0;
                if (!dn_state) begin
                    state_d = ST_LOCKOUT;
                    cnt_d   = CNT_LOAD;
                end
            end
            ST_LOCKOUT: begin
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        pg_state_d = (state_d == ST_UP_OWN) || (state_d == ST_DN_OWN);
        if (state_d == ST_UP_OWN) begin
            owner_d = OWNER_UP;
        end else if (state_d == ST_DN_OWN) begin
            owner_d = OWNER_DN;
        end else begin
            owner_d = OWNER_NONE;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            prio_up_q    <= 1'b1;
            owner_q      <= OWNER_NONE;
            pg_state_q   <= 1'b0;
            pg_posedge_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            prio_up_q    <= prio_up_d;
            owner_q      <= owner_d;
            pg_state_q   <= pg_state_d;
            pg_posedge_q <= pg_posedge_d;
        end
    end

    assign owner      = owner_q;
    assign pg_state   = pg_state_q;
    assign pg_posedge = pg_posedge_q;

    gray_pos_tracker #(
        .WIDTH (WIDTH)
    ) u_pos_tracker (
        .clk      (clk),
        .rst      (rst),
        .step_req (step_req),
        .step_dir (step_dir),
        .step     (step),
        .step_up  (step_up),
        .pos      (pos),
        .pos_gray (pos_gray),
        .at_limit (at_limit)
    );

endmodule
